// File: rtl/tohost_monitor.sv
// tohost_monitor: end-of-test monitor for the rv32ima system.
// Watches accepted data-memory writes to the riscv-tests tohost word and
// the x30/x31 signature registers. It reports a sticky pass, fail or timeout
// verdict, counts RUN cycles, and raises halt_req when a verdict exists.
//
// Ports
//   clk, nrst                 clock, async active-low reset
//   dmem_wen, dmem_ready      write request / accept (completion = both high)
//   dmem_addr, dmem_wdata     write byte address / data
//   rf_x30, rf_x31            live register-file contents
//   done, pass, fail, timeout verdict flags (done = any verdict)
//   test_id                   failing test number from the tohost write
//   cycles                    RUN cycles counted, saturating
//   halt_req                  mirrors done
module tohost_monitor #(
  parameter logic [31:0]     TOHOST_ADDR    = 32'h80001000,
  parameter logic [31:0]     SIG_VALUE      = 32'hBEEFBEEF,
  parameter longint unsigned TIMEOUT_CYCLES = 64'd1000000
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic        dmem_wen,
  input  logic        dmem_ready,
  input  logic [31:0] dmem_addr,
  input  logic [31:0] dmem_wdata,
  input  logic [31:0] rf_x30,
  input  logic [31:0] rf_x31,
  output logic        done,
  output logic        pass,
  output logic        fail,
  output logic        timeout,
  output logic [30:0] test_id,
  output logic [31:0] cycles,
  output logic        halt_req
);

  localparam int unsigned CNT_W = 32;
  localparam int unsigned ID_W  = 31;

  // One-hot terminal states so each verdict flag is a state flop bit.
  localparam logic [2:0] ST_RUN     = 3'b000;
  localparam logic [2:0] ST_PASS    = 3'b001;
  localparam logic [2:0] ST_FAIL    = 3'b010;
  localparam logic [2:0] ST_TIMEOUT = 3'b100;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [2:0]       state_q, state_d;
  logic [ID_W-1:0]  test_id_q, test_id_d;
  logic [CNT_W-1:0] cycles_q, cycles_d;
  logic             done_q;

  logic tohost_wr;
  logic pass_ev;
  logic fail_ev;
  logic sig_ev;
  logic timeout_hit;

  // Byte offset of the write address is deliberately ignored.
  logic unused_addr_lsbs;
  assign unused_addr_lsbs = ^dmem_addr[1:0];

  // Event decode and next-state / next-counter logic.
  always_comb begin
    state_d     = state_q;
    test_id_d   = test_id_q;
    cycles_d    = cycles_q;
    tohost_wr   = dmem_wen & dmem_ready & (dmem_addr[31:2] == TOHOST_ADDR[31:2]);
    pass_ev     = tohost_wr & (dmem_wdata == 32'd1);
    fail_ev     = tohost_wr & dmem_wdata[0] & (dmem_wdata != 32'd1);
    sig_ev      = (rf_x30 == SIG_VALUE) & (rf_x31 == SIG_VALUE);
    timeout_hit = (64'(cycles_q) == (TIMEOUT_CYCLES - 64'd1));

    if (state_q == ST_RUN) begin
      // Count includes the edge that leaves RUN.
      cycles_d = (cycles_q == CNT_MAX) ? cycles_q : cycles_q + CNT_W'(1);
      if (fail_ev) begin
        state_d   = ST_FAIL;
        test_id_d = dmem_wdata[31:1];
      end else if (pass_ev || sig_ev) begin
        state_d = ST_PASS;
      end else if (timeout_hit) begin
        state_d = ST_TIMEOUT;
      end
    end
  end

  // State, counter and verdict registers.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q   <= ST_RUN;
      test_id_q <= '0;
      cycles_q  <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      test_id_q <= test_id_d;
      cycles_q  <= cycles_d;
      done_q    <= (state_d != ST_RUN);
    end
  end

  assign pass     = state_q[0];
  assign fail     = state_q[1];
  assign timeout  = state_q[2];
  assign done     = done_q;
  assign halt_req = done_q;
  assign test_id  = test_id_q;
  assign cycles   = cycles_q;

endmodule
